// File: rtl/multiply_accumulate_channelised_if.sv
// Stream bus for the channelised MAC: input pair handshake plus result handshake and status.
interface multiply_accumulate_channelised_if #(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned COEFFICIENT_WIDTH = 16,
  parameter int unsigned OUTPUT_WIDTH      = 16,
  parameter int unsigned CHANNEL_WIDTH     = 2
);
  logic [DATA_WIDTH-1:0]        data_in;
  logic [COEFFICIENT_WIDTH-1:0] coefficient_in;
  logic                         data_in_valid;
  logic                         data_in_ready;
  logic [OUTPUT_WIDTH-1:0]      data_out;
  logic [CHANNEL_WIDTH-1:0]     data_out_channel;
  logic                         data_out_valid;
  logic                         data_out_ready;
  logic                         overflow;

  modport master (
    output data_in, coefficient_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_channel, data_out_valid, overflow
  );

  modport slave (
    input  data_in, coefficient_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_channel, data_out_valid, overflow
  );
endinterface

// File: rtl/multiply_accumulate_channelised.sv
// Time-multiplexed multiply-accumulate with one accumulator per interleaved channel.
// MAC_SATURATE_EN selects round-half-up + saturation on the output; default is plain truncation.
module multiply_accumulate_channelised #(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned COEFFICIENT_WIDTH = 16,
  parameter int unsigned ACCUMULATOR_WIDTH = 48,
  parameter int unsigned OUTPUT_WIDTH      = 16,
  parameter int unsigned OUTPUT_OFFSET     = 15,
  parameter int unsigned NUMBER_CHANNELS   = 4,
  parameter int unsigned ACCUMULATE_LENGTH = 8
) (
  input logic clock,
  input logic reset,
  input logic clear,
  multiply_accumulate_channelised_if.slave bus
);

  localparam int unsigned PW   = DATA_WIDTH + COEFFICIENT_WIDTH;
  localparam int unsigned AW   = ACCUMULATOR_WIDTH;
  localparam int unsigned OW   = OUTPUT_WIDTH;
  localparam int unsigned CW   = (NUMBER_CHANNELS > 1) ? $clog2(NUMBER_CHANNELS) : 1;
  localparam int unsigned SW   = (ACCUMULATE_LENGTH > 1) ? $clog2(ACCUMULATE_LENGTH) : 1;
  localparam int unsigned NACC = 2 ** CW;
  localparam logic [CW-1:0] LAST_CHANNEL = CW'(NUMBER_CHANNELS - 1);
  localparam logic [SW-1:0] LAST_SAMPLE  = SW'(ACCUMULATE_LENGTH - 1);

  typedef struct packed {
    logic [CW-1:0] channel;
    logic          first;
    logic          last;
  } tag_t;

  logic                                stall;
  logic                                accept;
  logic [CW-1:0]                       channel_count;
  logic [SW-1:0]                       sample_count;

  logic                                in_valid;
  logic signed [DATA_WIDTH-1:0]        in_data;
  logic signed [COEFFICIENT_WIDTH-1:0] in_coef;
  tag_t                                in_tag;

  logic                                prod_valid;
  logic signed [PW-1:0]                prod;
  tag_t                                prod_tag;

  logic signed [AW-1:0]                acc [NACC];
  logic signed [AW-1:0]                prod_ext;
  logic signed [AW-1:0]                next_acc;
  logic                                sum_valid;
  logic signed [AW-1:0]                sum_q;
  logic [CW-1:0]                       sum_channel;

  logic [OW-1:0]                       scaled;
  logic                                saturate;

  // A held result freezes the whole pipeline so nothing is ever dropped.
  assign stall             = bus.data_out_valid && !bus.data_out_ready;
  assign bus.data_in_ready = !stall;
  assign accept            = bus.data_in_valid && !stall && !clear;

  // Channel-major position of the next accepted pair.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      channel_count <= '0;
      sample_count  <= '0;
    end else if (clear) begin
      channel_count <= '0;
      sample_count  <= '0;
    end else if (accept) begin
      if (channel_count == LAST_CHANNEL) begin
        channel_count <= '0;
        sample_count  <= (sample_count == LAST_SAMPLE) ? '0 : sample_count + SW'(1);
      end else begin
        channel_count <= channel_count + CW'(1);
      end
    end
  end

  // Input and product registers, both tagged with the pair's position.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_valid   <= 1'b0;
      in_data    <= '0;
      in_coef    <= '0;
      in_tag     <= '0;
      prod_valid <= 1'b0;
      prod       <= '0;
      prod_tag   <= '0;
    end else if (clear) begin
      in_valid   <= 1'b0;
      prod_valid <= 1'b0;
    end else if (!stall) begin
      in_valid   <= accept;
      prod_valid <= in_valid;
      if (accept) begin
        in_data        <= bus.data_in;
        in_coef        <= bus.coefficient_in;
        in_tag.channel <= channel_count;
        in_tag.first   <= (sample_count == '0);
        in_tag.last    <= (sample_count == LAST_SAMPLE);
      end
      if (in_valid) begin
        prod     <= PW'(in_data) * PW'(in_coef);
        prod_tag <= in_tag;
      end
    end
  end

  assign prod_ext = AW'(prod);
  assign next_acc = prod_tag.first ? prod_ext : acc[prod_tag.channel] + prod_ext;

  // Per-channel accumulate; sum_q carries the updated value to the output stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NACC; i++) acc[i] <= '0;
      sum_valid   <= 1'b0;
      sum_q       <= '0;
      sum_channel <= '0;
    end else if (clear) begin
      sum_valid <= 1'b0;
    end else if (!stall) begin
      sum_valid <= prod_valid && prod_tag.last;
      if (prod_valid) begin
        acc[prod_tag.channel] <= next_acc;
        sum_q                 <= next_acc;
        sum_channel           <= prod_tag.channel;
      end
    end
  end

`ifdef MAC_SATURATE_EN
  localparam logic [AW:0] ROUND =
    (OUTPUT_OFFSET > 0) ? ((AW+1)'(1) << ((OUTPUT_OFFSET > 0) ? OUTPUT_OFFSET - 1 : 0)) : '0;

  logic signed [AW:0]   rounded;
  logic signed [AW:0]   shifted;
  logic [AW-OW+1:0]     upper;

  // Extra headroom bit keeps the rounding add from wrapping.
  always_comb begin
    rounded  = {sum_q[AW-1], sum_q} + ROUND;
    shifted  = rounded >>> OUTPUT_OFFSET;
    upper    = shifted[AW:OW-1];
    saturate = !((&upper) || !(|upper));
    scaled   = shifted[OW-1:0];
    if (saturate) scaled = shifted[AW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
  end
`else
  logic sum_unused;

  assign scaled     = sum_q[OUTPUT_OFFSET +: OW];
  assign saturate   = 1'b0;
  assign sum_unused = ^sum_q;
`endif

  // Result register: frees on handshake and may reload on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.data_out         <= '0;
      bus.data_out_channel <= '0;
      bus.data_out_valid   <= 1'b0;
      bus.overflow         <= 1'b0;
    end else if (clear) begin
      bus.data_out_valid <= 1'b0;
    end else if (!stall) begin
      bus.data_out_valid <= sum_valid;
      if (sum_valid) begin
        bus.data_out         <= scaled;
        bus.data_out_channel <= sum_channel;
        bus.overflow         <= bus.overflow | saturate;
      end
    end
  end

endmodule

// File: tb/tb_multiply_accumulate_channelised.sv
// Bench for multiply_accumulate_channelised: directed spec scenarios plus random traffic
// scored against an arithmetic per-channel sum model.
module tb_multiply_accumulate_channelised;

  localparam int N   = 2;
  localparam int L   = 3;
  localparam int OFF = 0;

  typedef struct {
    logic [15:0] d;
    logic        ch;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic clear;
  logic clear_r;

  always #5 clock = ~clock;

  multiply_accumulate_channelised_if #(.CHANNEL_WIDTH(1)) m ();
  multiply_accumulate_channelised_if #(.CHANNEL_WIDTH(1)) r ();

  multiply_accumulate_channelised #(
    .NUMBER_CHANNELS(N), .ACCUMULATE_LENGTH(L), .OUTPUT_OFFSET(OFF)
  ) dut (.clock(clock), .reset(reset), .clear(clear), .bus(m));

  multiply_accumulate_channelised #(
    .NUMBER_CHANNELS(1), .ACCUMULATE_LENGTH(1), .OUTPUT_OFFSET(1)
  ) dut_r (.clock(clock), .reset(reset), .clear(clear_r), .bus(r));

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          idx   = 0;
  longint      sums [N];
  logic        ovf_exp;
  exp_t        exp_q [$];
  int          acc_cyc [$];
  int          out_cyc [$];
  logic [15:0] out_d [$];
  logic        out_ch [$];
  logic [15:0] bd [6];
  logic [15:0] bc [6];
  logic        ok;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_scale(input longint s, input int off, output logic sat);
`ifdef MAC_SATURATE_EN
    longint rv;
    rv = (off > 0) ? ((s + (longint'(1) << (off - 1))) >>> off) : s;
    sat = 1'b1;
    if (rv > 32767) return 16'h7FFF;
    if (rv < -32768) return 16'h8000;
    sat = 1'b0;
    return 16'(rv);
`else
    sat = 1'b0;
    return 16'(s >>> off);
`endif
  endfunction

  // Spec-level model: pair i belongs to channel i%N, step (i/N)%L.
  task automatic model_accept(input logic [15:0] d, input logic [15:0] c);
    int     ch;
    int     s;
    longint p;
    logic   sat;
    exp_t   e;
    ch = idx % N;
    s  = (idx / N) % L;
    p  = longint'($signed(d)) * longint'($signed(c));
    sums[ch] = (s == 0) ? p : sums[ch] + p;
    if (s == L - 1) begin
      e.d  = model_scale(sums[ch], OFF, sat);
      e.ch = 1'(ch);
      exp_q.push_back(e);
      ovf_exp = ovf_exp | sat;
    end
    acc_cyc.push_back(cyc);
    idx++;
  endtask

  task automatic flush();
    idx = 0;
    exp_q.delete();
    acc_cyc.delete();
  endtask

  task automatic clear_log();
    acc_cyc.delete();
    out_cyc.delete();
    out_d.delete();
    out_ch.delete();
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("spurious_valid", m.data_out_valid, 1'b0);
    end else begin
      e = exp_q.pop_front();
      chk("sb_data", m.data_out, e.d);
      chk("sb_channel", m.data_out_channel, e.ch);
      out_d.push_back(m.data_out);
      out_ch.push_back(m.data_out_channel);
      out_cyc.push_back(cyc - 1);
    end
  endtask

  // One clock of stimulus on the main DUT; handshakes are judged before the edge.
  task automatic cycle(input logic v, input logic [15:0] d, input logic [15:0] c,
                       input logic ordy, input logic clr, output logic acc_ok);
    m.data_in_valid  = v;
    m.data_in        = d;
    m.coefficient_in = c;
    m.data_out_ready = ordy;
    clear            = clr;
    #1;
    acc_ok = 1'b0;
    if (m.data_out_valid && ordy && !clr) check_out();
    if (clr) flush();
    else if (v && m.data_in_ready) begin
      model_accept(d, c);
      acc_ok = 1'b1;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic send_pair(input logic [15:0] d, input logic [15:0] c, input logic ordy);
    logic got;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) cycle(1'b1, d, c, ordy, 1'b0, got);
    if (!got) chk("send_timeout", m.data_in_ready, 1'b1);
  endtask

  task automatic send_basic(input logic ordy);
    for (int i = 0; i < 6; i++) send_pair(bd[i], bc[i], ordy);
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && exp_q.size() > 0; t++) cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, ok);
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 12 && !m.data_out_valid; t++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ok);
    chk("wait_valid", m.data_out_valid, 1'b1);
  endtask

  task automatic check_basic(input string tag);
    chk({tag, "_count"}, out_d.size(), 2);
    if (out_d.size() >= 2) begin
      chk({tag, "_d0"}, out_d[0], 16'h000C);
      chk({tag, "_c0"}, out_ch[0], 1'b0);
      chk({tag, "_d1"}, out_d[1], 16'hFFE2);
      chk({tag, "_c1"}, out_ch[1], 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_v;
    logic        sat;
    int          lat;
    bd = '{16'd1, 16'd10, 16'd2, 16'd10, 16'd3, 16'd10};
    bc = '{16'd2, 16'hFFFF, 16'd2, 16'hFFFF, 16'd2, 16'hFFFF};
    reset = 1'b1; clear = 1'b0; clear_r = 1'b0; ovf_exp = 1'b0;
    m.data_in_valid = 1'b0; m.data_in = '0; m.coefficient_in = '0; m.data_out_ready = 1'b1;
    r.data_in_valid = 1'b0; r.data_in = '0; r.coefficient_in = '0; r.data_out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_data", m.data_out, 16'h0);
    chk("rst_channel", m.data_out_channel, 1'b0);
    chk("rst_valid", m.data_out_valid, 1'b0);
    chk("rst_overflow", m.overflow, 1'b0);
    chk("rst_in_ready", m.data_in_ready, 1'b1);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Basic sequence and its latency.
    clear_log();
    send_basic(1'b1);
    drain();
    check_basic("t1");
    if (out_cyc.size() >= 2 && acc_cyc.size() >= 5) begin
      chk("t1_latency", out_cyc[0] - acc_cyc[4], 3);
      chk("t1_ch1_next", out_cyc[1] - out_cyc[0], 1);
    end

    // Backpressure holds the first result and blocks input.
    clear_log();
    send_basic(1'b0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ok);
      chk("t2_in_ready", m.data_in_ready, 1'b0);
      chk("t2_hold_data", m.data_out, 16'h000C);
      chk("t2_hold_ch", m.data_out_channel, 1'b0);
    end
    drain();
    check_basic("t2");

    // Full-scale products.
    clear_log();
    for (int i = 0; i < 6; i++) send_pair(16'h7FFF, 16'h7FFF, 1'b1);
    drain();
`ifdef MAC_SATURATE_EN
    exp_v = 16'h7FFF;
`else
    exp_v = 16'h0003;
`endif
    chk("t3_count", out_d.size(), 2);
    if (out_d.size() >= 2) begin
      chk("t3_d0", out_d[0], exp_v);
      chk("t3_d1", out_d[1], exp_v);
    end
`ifdef MAC_SATURATE_EN
    chk("t3_overflow", m.overflow, 1'b1);
`else
    chk("t3_overflow", m.overflow, 1'b0);
`endif

    // Clear while a result is held, then mid-sequence, then a fresh run.
    clear_log();
    send_basic(1'b0);
    wait_valid();
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, ok);
    chk("t6_valid_drop", m.data_out_valid, 1'b0);
    chk("t6_in_ready", m.data_in_ready, 1'b1);
    for (int i = 0; i < 3; i++) send_pair(bd[i], bc[i], 1'b1);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, ok);
    clear_log();
    send_basic(1'b1);
    drain();
    check_basic("t6");
    chk("t6_overflow", m.overflow, ovf_exp);

    // Rounding on the single-channel, single-step instance.
    r.data_in = 16'd3; r.coefficient_in = 16'd1; r.data_in_valid = 1'b1;
    @(posedge clock);
    #1;
    r.data_in_valid = 1'b0;
    lat = 0;
    for (int t = 1; t <= 10 && lat == 0; t++) begin
      @(posedge clock);
      #1;
      if (r.data_out_valid) lat = t;
    end
    exp_v = model_scale(64'sd3, 1, sat);
    chk("t4_latency", lat, 3);
    chk("t4_data", r.data_out, exp_v);
    chk("t4_overflow", r.overflow, 1'b0);

    // Reset mid-accumulation aborts everything.
    clear_log();
    for (int i = 0; i < 4; i++) send_pair(bd[i], bc[i], 1'b1);
    m.data_in_valid = 1'b0;
    reset = 1'b1;
    #2;
    chk("t5_rst_valid", m.data_out_valid, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    flush();
    ovf_exp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, ok);
      chk("t5_quiet", m.data_out_valid, 1'b0);
    end
    chk("t5_overflow", m.overflow, 1'b0);
    clear_log();
    send_basic(1'b1);
    drain();
    check_basic("t5");

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++)
      cycle(($urandom % 4) != 0, 16'($urandom), 16'($urandom), ($urandom % 4) != 0, 1'b0, ok);
    drain();
    chk("rand_overflow", m.overflow, ovf_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
